// File: rtl/ctrl_frame_gen_if.sv
// ctrl_bus: start/valid/stop framing lines between the frame generator
// (master) and its consumer such as ctrl_mac (slave).
//   start : one-cycle frame header, never together with valid
//   valid : one data beat per cycle while high
//   stop  : marks the last beat of a frame, always together with valid
interface ctrl_bus;
    logic start;
    logic valid;
    logic stop;

    modport master (output start, output valid, output stop);
    modport slave  (input  start, input  valid, input  stop);
endinterface

// File: rtl/ctrl_frame_gen.sv
// ctrl_frame_gen: transmitter side of the ctrl_bus framing protocol.
// On an accepted req it emits out_size frames, each made of one start cycle
// followed by in_size valid beats (stop on the last beat), with GAP idle
// cycles between frames. Input/weight read addresses accompany every beat.
// Ports:
//   clk, xrst            clock (rising edge), asynchronous active-low reset
//   req                  start a layer, sampled only while idle
//   in_size, out_size    beats per frame (N) and frames per layer (M)
//   hold                 stall beat issue while high
//   ack                  high while idle
//   out_ctrl             ctrl_bus master (start/valid/stop)
//   in_addr              input address of the current beat, 0..N-1
//   w_addr               weight address, continuous across frames
//   frame_idx            index of the current frame
//   done                 one-cycle pulse after the last frame
// Every output is a register; hold/req take effect on the following cycle.
module ctrl_frame_gen #(
    parameter int SIZEW  = 16,
    parameter int WADDRW = 20,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              req,
    input  logic [SIZEW-1:0]  in_size,
    input  logic [SIZEW-1:0]  out_size,
    input  logic              hold,
    output logic              ack,
    ctrl_bus.master           out_ctrl,
    output logic [SIZEW-1:0]  in_addr,
    output logic [WADDRW-1:0] w_addr,
    output logic [SIZEW-1:0]  frame_idx,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BODY  = 3'd2,
        ST_GAP   = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam logic [SIZEW-1:0]  ONE_S = SIZEW'(1);
    localparam logic [WADDRW-1:0] ONE_W = WADDRW'(1);
    localparam logic [15:0]       GAP_L = 16'(GAP);

    state_t             state_r, state_s;
    logic [SIZEW-1:0]   n_r, n_s, m_r, m_s;
    logic [SIZEW-1:0]   beat_r, beat_s;       // beats issued in the current frame
    logic [15:0]        gap_r, gap_s;         // gap cycles shown so far
    logic [SIZEW-1:0]   frame_r, frame_s;
    logic [SIZEW-1:0]   in_addr_r, in_addr_s;
    logic [WADDRW-1:0]  w_addr_r, w_addr_s;
    logic [WADDRW-1:0]  w_next_r, w_next_s;   // weight address of the next beat
    logic               start_r, start_s, valid_r, valid_s, stop_r, stop_s;
    logic               done_r, done_s, ack_r, ack_s;
    logic [SIZEW-1:0]   beat_inc_s, frame_inc_s;

    assign beat_inc_s  = beat_r + ONE_S;
    assign frame_inc_s = frame_r + ONE_S;

    // State and output registers; reset drops all framing lines immediately.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_r   <= ST_IDLE;
            n_r       <= '0;
            m_r       <= '0;
            beat_r    <= '0;
            gap_r     <= 16'd0;
            frame_r   <= '0;
            in_addr_r <= '0;
            w_addr_r  <= '0;
            w_next_r  <= '0;
            start_r   <= 1'b0;
            valid_r   <= 1'b0;
            stop_r    <= 1'b0;
            done_r    <= 1'b0;
            ack_r     <= 1'b1;
        end else begin
            state_r   <= state_s;
            n_r       <= n_s;
            m_r       <= m_s;
            beat_r    <= beat_s;
            gap_r     <= gap_s;
            frame_r   <= frame_s;
            in_addr_r <= in_addr_s;
            w_addr_r  <= w_addr_s;
            w_next_r  <= w_next_s;
            start_r   <= start_s;
            valid_r   <= valid_s;
            stop_r    <= stop_s;
            done_r    <= done_s;
            ack_r     <= ack_s;
        end
    end

    // Next state plus the output values to be shown during the next cycle.
    always_comb begin
        state_s   = state_r;
        n_s       = n_r;
        m_s       = m_r;
        beat_s    = beat_r;
        gap_s     = gap_r;
        frame_s   = frame_r;
        in_addr_s = in_addr_r;
        w_addr_s  = w_addr_r;
        w_next_s  = w_next_r;
        start_s   = 1'b0;
        valid_s   = 1'b0;
        stop_s    = 1'b0;
        done_s    = 1'b0;
        ack_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    n_s       = in_size;
                    m_s       = out_size;
                    beat_s    = '0;
                    frame_s   = '0;
                    in_addr_s = '0;
                    w_addr_s  = '0;
                    w_next_s  = '0;
                    if ((in_size != '0) && (out_size != '0)) begin
                        state_s = ST_START;
                        start_s = 1'b1;
                    end else begin
                        state_s = ST_FIN;
                        done_s  = 1'b1;
                    end
                end else begin
                    ack_s = 1'b1;
                end
            end
            ST_START: begin
                // First beat always follows the start cycle; hold is not looked at here.
                state_s   = ST_BODY;
                valid_s   = 1'b1;
                stop_s    = (beat_inc_s == n_r);
                in_addr_s = beat_r;
                w_addr_s  = w_next_r;
                w_next_s  = w_next_r + ONE_W;
                beat_s    = beat_inc_s;
            end
            ST_BODY: begin
                if (beat_r == n_r) begin
                    // Last beat has just been shown: close the frame.
                    if (frame_inc_s == m_r) begin
                        state_s = ST_FIN;
                        done_s  = 1'b1;
                    end else if (GAP_L == 16'd0) begin
                        state_s   = ST_START;
                        start_s   = 1'b1;
                        frame_s   = frame_inc_s;
                        in_addr_s = '0;
                        beat_s    = '0;
                    end else begin
                        state_s = ST_GAP;
                        gap_s   = 16'd1;
                    end
                end else if (hold) begin
                    state_s = ST_BODY;
                end else begin
                    valid_s   = 1'b1;
                    stop_s    = (beat_inc_s == n_r);
                    in_addr_s = beat_r;
                    w_addr_s  = w_next_r;
                    w_next_s  = w_next_r + ONE_W;
                    beat_s    = beat_inc_s;
                end
            end
            ST_GAP: begin
                if (gap_r >= GAP_L) begin
                    state_s   = ST_START;
                    start_s   = 1'b1;
                    frame_s   = frame_inc_s;
                    in_addr_s = '0;
                    beat_s    = '0;
                end else begin
                    gap_s = gap_r + 16'd1;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
                ack_s   = 1'b1;
            end
            default: begin
                state_s = ST_IDLE;
                ack_s   = 1'b1;
            end
        endcase
    end

    assign out_ctrl.start = start_r;
    assign out_ctrl.valid = valid_r;
    assign out_ctrl.stop  = stop_r;
    assign ack            = ack_r;
    assign in_addr        = in_addr_r;
    assign w_addr         = w_addr_r;
    assign frame_idx      = frame_r;
    assign done           = done_r;

endmodule

// File: tb/tb_ctrl_frame_gen.sv
// Bench for ctrl_frame_gen: for each layer request it builds the expected
// per-cycle output trace from the framing rules (frames, beats, hold stalls,
// gaps, done), then drives the request and compares every cycle.
module tb_ctrl_frame_gen;
    localparam int SIZEW  = 16;
    localparam int WADDRW = 20;
    localparam int GAP    = 2;
    localparam int TLEN   = 2048;

    logic              clk = 1'b0;
    logic              xrst = 1'b0;
    logic              req = 1'b0;
    logic              hold = 1'b0;
    logic [SIZEW-1:0]  in_size = 16'd0;
    logic [SIZEW-1:0]  out_size = 16'd0;
    logic              ack, done;
    logic [SIZEW-1:0]  in_addr, frame_idx;
    logic [WADDRW-1:0] w_addr;

    ctrl_bus bus ();

    ctrl_frame_gen #(.SIZEW(SIZEW), .WADDRW(WADDRW), .GAP(GAP)) dut (
        .clk(clk), .xrst(xrst), .req(req), .in_size(in_size), .out_size(out_size),
        .hold(hold), .ack(ack), .out_ctrl(bus), .in_addr(in_addr), .w_addr(w_addr),
        .frame_idx(frame_idx), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic        hv [0:TLEN-1];
    logic [56:0] exp_tr [0:TLEN-1];
    int          exp_len;

    function automatic logic [56:0] pack(input logic a, input logic s, input logic v,
                                         input logic p, input logic d, input int f,
                                         input int ia, input int w);
        return {a, s, v, p, d, 16'(f), 16'(ia), 20'(w)};
    endfunction

    function automatic logic [56:0] observe();
        return {ack, bus.start, bus.valid, bus.stop, done, frame_idx, in_addr, w_addr};
    endfunction

    task automatic set_hold(input int pct);
        for (int i = 0; i < TLEN; i++) hv[i] = ($urandom_range(99) < pct);
    endtask

    // Expected trace: cycle 0 carries req, frames start at cycle 1.
    task automatic build_exp(input int n, input int m);
        int c, ia, w;
        c = 1; ia = 0; w = 0;
        if (n == 0 || m == 0) begin
            exp_tr[1] = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
            exp_tr[2] = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
            exp_len = 3;
        end else begin
            for (int f = 0; f < m; f++) begin
                exp_tr[c] = pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, f, 0, w);
                c++;
                for (int k = 0; k < n; k++) begin
                    // A beat after the first waits while hold was high one cycle earlier.
                    while (k > 0 && hv[c-1] && c < TLEN - 8) begin
                        exp_tr[c] = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, f, ia, w);
                        c++;
                    end
                    ia = k;
                    w  = (f * n + k) % (1 << WADDRW);
                    exp_tr[c] = pack(1'b0, 1'b0, 1'b1, (k == n - 1), 1'b0, f, ia, w);
                    c++;
                end
                if (f < m - 1) begin
                    for (int g = 0; g < GAP; g++) begin
                        exp_tr[c] = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, f, ia, w);
                        c++;
                    end
                end
            end
            exp_tr[c]     = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m - 1, ia, w);
            exp_tr[c + 1] = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m - 1, ia, w);
            exp_len = c + 2;
        end
    endtask

    // Run one layer; mid_req re-pulses req with another size during the body,
    // abort_at > 0 pulls xrst low in that cycle instead of finishing.
    task automatic run_layer(input int n, input int m, input bit mid_req, input int abort_at);
        logic [56:0] obs;
        build_exp(n, m);
        @(negedge clk);
        total++;
        assert (ack === 1'b1)
        else begin
            bad++;
            $error("FAIL idle_ack n=%0d m=%0d: observed %b expected 1", n, m, ack);
        end
        in_size  = 16'(n);
        out_size = 16'(m);
        req      = 1'b1;
        hold     = hv[0];
        for (int j = 1; j < exp_len; j++) begin
            @(negedge clk);
            if (abort_at == j) begin
                xrst = 1'b0;
                #1;
                obs = observe();
                total++;
                assert (obs[56:52] === 5'b10000)
                else begin
                    bad++;
                    $error("FAIL reset_drop cycle %0d: observed %b expected 10000", j, obs[56:52]);
                end
                @(negedge clk);
                xrst = 1'b1;
                req  = 1'b0;
                hold = 1'b0;
                return;
            end
            obs = observe();
            total++;
            assert (obs === exp_tr[j])
            else begin
                bad++;
                $error("FAIL trace n=%0d m=%0d cycle %0d: observed %h expected %h",
                       n, m, j, obs, exp_tr[j]);
            end
            req = mid_req && (j == 2);
            if (req) in_size = 16'(n + 7);
            hold = hv[j];
        end
        req  = 1'b0;
        hold = 1'b0;
    endtask

    initial begin
        int rn, rm;
        #12;
        total++;
        assert (observe() === pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0))
        else begin
            bad++;
            $error("FAIL reset_state: observed %h expected %h", observe(),
                   pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0));
        end
        @(negedge clk);
        xrst = 1'b1;

        // Long single frame.
        set_hold(0);
        run_layer(800, 1, 1'b0, 0);
        // Several frames with gaps.
        run_layer(3, 4, 1'b0, 0);
        // Three-cycle hold in the middle of a frame.
        set_hold(0);
        hv[3] = 1'b1; hv[4] = 1'b1; hv[5] = 1'b1;
        run_layer(5, 1, 1'b0, 0);
        // Single-beat frames and empty layers.
        set_hold(0);
        run_layer(1, 2, 1'b0, 0);
        run_layer(0, 3, 1'b0, 0);
        run_layer(4, 0, 1'b0, 0);
        // Reset in mid frame, then a clean restart from address zero.
        run_layer(100, 1, 1'b0, 40);
        run_layer(2, 2, 1'b0, 0);
        // req during the body must be ignored.
        run_layer(6, 2, 1'b1, 0);
        // Randomised layers with random hold.
        for (int it = 0; it < 12; it++) begin
            rn = $urandom_range(10, 1);
            rm = $urandom_range(4, 1);
            set_hold(30);
            run_layer(rn, rm, 1'($urandom_range(1)), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
